// File: rtl/tcb_img_feeder_121.sv
// Host-side feeder for the 121-64-10 TCB MNIST top: packs a byte-serial 11x11 frame, starts one inference, returns the digit.
// Optional build macro FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that returns an all-ones error result.
module tcb_img_feeder_121 #(
  parameter int N_PIX   = 121,
  parameter int PIX_W   = 8,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [N_PIX*PIX_W-1:0] img_out,
  output logic                   start_out,
  input  logic                   done_in,
  input  logic [RES_W-1:0]       number_in,
  output logic [RES_W-1:0]       result,
  output logic                   result_err,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy
);

  localparam int IDX_W = 7;

  typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_RESULT} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_PIX*PIX_W-1:0] img_q, img_d;
  logic [RES_W-1:0]       res_q, res_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   rvalid_q, rvalid_d;
  logic                   accept_s;
  logic                   last_s;

`ifdef FEEDER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // pix_ready is the only combinational output; forced low while reset is held
  assign pix_ready = (state_q == ST_LOAD) & rst;
  assign accept_s  = pix_valid & pix_ready;
  assign last_s    = (idx_q == IDX_W'(N_PIX - 1));

  // Next-state, frame packing and result capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    img_d   = img_q;
    res_d   = res_q;
`ifdef FEEDER_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          img_d[idx_q*PIX_W +: PIX_W] = pix_in;
          if (last_s) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done_in takes priority over an expiring watchdog
        if (done_in) begin
          res_d   = number_in;
          state_d = ST_RESULT;
`ifdef FEEDER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d   = '1;
          err_d   = 1'b1;
          state_d = ST_RESULT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`else
        end else begin
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RESULT: begin
        if (result_ready) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    start_d  = (state_d == ST_START);
    busy_d   = (state_d == ST_START) | (state_d == ST_WAIT);
    rvalid_d = (state_d == ST_RESULT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      img_q    <= '0;
      res_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      img_q    <= img_d;
      res_q    <= res_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
`ifdef FEEDER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign img_out      = img_q;
  assign start_out    = start_q;
  assign result       = res_q;
  assign result_valid = rvalid_q;
  assign busy         = busy_q;
`ifdef FEEDER_TIMEOUT_EN
  assign result_err   = err_q;
`else
  assign result_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tcb_img_feeder_121.sv
// Directed bench for tcb_img_feeder_121: frame loads, network handshake, back-pressure, spurious done, mid-frame reset.
module tb_tcb_img_feeder_121;
  localparam int N_PIX   = 121;
  localparam int PIX_W   = 8;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 100;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [PIX_W-1:0]       pix_in = '0;
  logic                   pix_valid = 1'b0;
  logic                   pix_ready;
  logic [N_PIX*PIX_W-1:0] img_out;
  logic                   start_out;
  logic                   done_in = 1'b0;
  logic [RES_W-1:0]       number_in = '0;
  logic [RES_W-1:0]       result;
  logic                   result_err;
  logic                   result_valid;
  logic                   result_ready = 1'b0;
  logic                   busy;

  always #5 clk = ~clk;

  tcb_img_feeder_121 #(.N_PIX(N_PIX), .PIX_W(PIX_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .img_out(img_out), .start_out(start_out), .done_in(done_in), .number_in(number_in),
    .result(result), .result_err(result_err), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [PIX_W-1:0]       frame [N_PIX];
  logic [N_PIX*PIX_W-1:0] exp_img;
  logic [RES_W:0]         sb [$];
  logic [RES_W-1:0]       held_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  function automatic void build_frame(input int mode);
    for (int i = 0; i < N_PIX; i++) begin
      frame[i] = (mode == 0) ? PIX_W'(i) : PIX_W'($urandom);
      exp_img[i*PIX_W +: PIX_W] = frame[i];
    end
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pix_ready"}, 64'(pix_ready), 64'd0);
    chk({tag, "_img_zero"}, 64'(img_out === '0), 64'd1);
    chk({tag, "_start"}, 64'(start_out), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_err"}, 64'(result_err), 64'd0);
    chk({tag, "_valid"}, 64'(result_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Sends frame[first..stop-1]; ends at the observation point one cycle after the last accepted beat
  task automatic send_frame(input int first, input int stop, input int gap_pct, input int spur_at);
    int sent;
    int budget;
    int early;
    sent = first;
    budget = 0;
    early = 0;
    while (sent < stop && budget < 4000) begin
      adv();
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_in    = frame[sent];
      done_in   = (sent == spur_at);
      number_in = (sent == spur_at) ? 32'd99 : 32'd0;
      obs();
      if (start_out) early++;
      if (pix_valid && pix_ready) sent++;
      budget++;
    end
    adv();
    pix_valid = 1'b0;
    done_in   = 1'b0;
    obs();
    chk("beats_accepted", 64'(sent), 64'(stop));
    chk("no_early_start", 64'(early), 64'd0);
  endtask

  task automatic check_result();
    logic [RES_W:0] e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("result_valid", 64'(result_valid), 64'd1);
      chk("result", 64'(result), 64'(e[RES_W-1:0]));
      chk("result_err", 64'(result_err), 64'(e[RES_W]));
      chk("busy_in_result", 64'(busy), 64'd0);
      held_res = e[RES_W-1:0];
    end
  endtask

  // Called at the observation point of the START cycle; plays the network with a done pulse delay cycles after start
  task automatic net_and_result(input logic [RES_W-1:0] num, input int delay, input logic rdy);
    chk("start_pulse", 64'(start_out), 64'd1);
    chk("busy_start", 64'(busy), 64'd1);
    chk("pix_ready_busy", 64'(pix_ready), 64'd0);
    chk("no_spurious_result", 64'(result_valid), 64'd0);
    adv();
    obs();
    chk("start_one_cycle", 64'(start_out), 64'd0);
    chk("img_out_frame", 64'(img_out === exp_img), 64'd1);
    repeat (delay - 2) begin
      adv();
      obs();
    end
    adv();
    done_in      = 1'b1;
    number_in    = num;
    result_ready = rdy;
    sb.push_back({1'b0, num});
    obs();
    chk("no_result_before_done", 64'(result_valid), 64'd0);
    chk("busy_wait", 64'(busy), 64'd1);
    adv();
    done_in   = 1'b0;
    number_in = '0;
    obs();
    check_result();
    if (rdy) begin
      adv();
      obs();
      chk("valid_drop_after_hs", 64'(result_valid), 64'd0);
      chk("pix_ready_after_hs", 64'(pix_ready), 64'd1);
    end
  endtask

  initial begin
    // Reset and release
    repeat (3) adv();
    obs();
    chk_reset_vals("reset");
    adv();
    rst = 1'b1;
    obs();
    chk("pix_ready_release", 64'(pix_ready), 64'd1);

    // Ramp frame at full throughput, consumer always ready
    build_frame(0);
    result_ready = 1'b1;
    send_frame(0, N_PIX, 0, -1);
    chk("img_first_pixel", 64'(img_out[7:0]), 64'h00);
    chk("img_last_pixel", 64'(img_out[967:960]), 64'h78);
    net_and_result(32'd7, 50, 1'b1);

    // Random frame with ~30% idle beats; consumer stalls on the result
    build_frame(1);
    result_ready = 1'b0;
    send_frame(0, N_PIX, 30, -1);
    net_and_result(32'd5, 50, 1'b0);

    // Back-pressure: upstream presents the next frame while the result is held
    build_frame(1);
    repeat (20) begin
      adv();
      pix_valid = 1'b1;
      pix_in    = frame[0];
      obs();
      chk("hold_pix_ready", 64'(pix_ready), 64'd0);
      chk("hold_valid", 64'(result_valid), 64'd1);
      chk("hold_result", 64'(result), 64'(held_res));
    end
    adv();
    result_ready = 1'b1;
    obs();
    chk("hs_valid", 64'(result_valid), 64'd1);
    adv();
    obs();
    chk("hs_valid_drop", 64'(result_valid), 64'd0);
    chk("hs_pix_ready", 64'(pix_ready), 64'd1);

    // Rest of that frame, with a spurious done pulse mid-load
    send_frame(1, N_PIX, 10, 40);
    net_and_result(32'd3, 50, 1'b1);

    // Reset after 60 pixels, then a full frame from index 0
    build_frame(1);
    send_frame(0, 60, 0, -1);
    adv();
    rst = 1'b0;
    obs();
    chk_reset_vals("midreset");
    repeat (2) begin
      adv();
      obs();
    end
    chk("midreset_pix_ready_low", 64'(pix_ready), 64'd0);
    adv();
    rst = 1'b1;
    obs();
    chk("rerelease_pix_ready", 64'(pix_ready), 64'd1);
    chk("no_partial_start", 64'(start_out), 64'd0);
    build_frame(1);
    send_frame(0, N_PIX, 0, -1);
    net_and_result(32'd9, 50, 1'b1);

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog: no done pulse at all
    build_frame(0);
    send_frame(0, N_PIX, 0, -1);
    chk("to_start", 64'(start_out), 64'd1);
    sb.push_back({1'b1, 32'hFFFF_FFFF});
    repeat (TIMEOUT) begin
      adv();
      obs();
    end
    chk("to_not_yet", 64'(result_valid), 64'd0);
    adv();
    obs();
    check_result();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
